// File: rtl/funct_generator_ctrl.sv
// funct_generator_ctrl
//   Sequencer for the function-generator datapath. Computes waveform samples,
//   drives the external sample register (d / enh / clrh) and pushes each
//   registered sample into the downstream FIFO, honouring FIFO backpressure.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      start request (sampled in IDLE only)
//   stop       abort request (sampled in any non-IDLE state)
//   wave_sel   00 sawtooth, 01 triangle, 10 square, 11 ramp-down
//   div        sample period minus 1, in clk cycles
//   burst_len  number of samples to emit, 0 = continuous
//   fifo_full  FIFO full flag
//   sample_d   next sample, to register d
//   reg_enh    register load enable
//   reg_clrh   register synchronous clear
//   fifo_wr    FIFO write strobe (FIFO captures register q)
//   busy       state is not IDLE
//   done       one-cycle pulse on the final burst write
module funct_generator_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             wave_sel,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   fifo_full,
  output logic [DATA_WIDTH-1:0]  sample_d,
  output logic                   reg_enh,
  output logic                   reg_clrh,
  output logic                   fifo_wr,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;

  localparam logic [DATA_WIDTH-1:0]  P_ONE = DATA_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]   D_ONE = DIV_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] B_ONE = BURST_WIDTH'(1);

  state_t                 state, state_nx;
  logic [1:0]             wave_l;
  logic [DIV_WIDTH-1:0]   div_l;
  logic [BURST_WIDTH-1:0] blen_l;
  logic [DIV_WIDTH-1:0]   presc;
  logic [BURST_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  p, p_nx;
  logic                   dir_up, dir_nx;
  logic                   wr_pend, wr_pend_nx;
  logic                   blocked, exhausted, tick;
  logic [DATA_WIDTH-1:0]  wave_val;

  // A pending write that the FIFO refuses freezes the prescaler and
  // suppresses ticks, so the unwritten sample in the register is never
  // overwritten.
  assign blocked   = wr_pend & fifo_full;
  assign exhausted = (blen_l != '0) && (cnt == blen_l);
  assign tick      = (state == RUN) && !blocked && (presc == div_l);

  always_comb begin
    case (wave_l)
      2'b00:   wave_val = p;
      2'b01:   wave_val = p;
      2'b10:   wave_val = {DATA_WIDTH{p[DATA_WIDTH-1]}};
      default: wave_val = ~p;
    endcase
  end

  // Phase advance; for the triangle p holds v and bounces off the rails
  // without repeating the endpoint.
  always_comb begin
    p_nx   = p + P_ONE;
    dir_nx = dir_up;
    if (wave_l == 2'b01) begin
      if (dir_up) begin
        if (p == '1) begin
          p_nx   = p - P_ONE;
          dir_nx = 1'b0;
        end
      end else begin
        if (p == '0) begin
          p_nx   = P_ONE;
          dir_nx = 1'b1;
        end else begin
          p_nx = p - P_ONE;
        end
      end
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    sample_d = busy ? wave_val : '0;
    reg_enh  = tick & ~stop & ~exhausted;
    reg_clrh = (state == FLUSH);
    fifo_wr  = ((state == RUN) || (state == STALL)) & wr_pend & ~fifo_full;
    // Once every sample is loaded, the write that fires is the last one.
    done     = fifo_wr & exhausted & ~stop;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start && !stop) state_nx = RUN;
      RUN: begin
        if (stop)         state_nx = FLUSH;
        else if (done)    state_nx = IDLE;
        else if (blocked) state_nx = STALL;
      end
      STALL: begin
        if (stop)            state_nx = FLUSH;
        else if (!fifo_full) state_nx = done ? IDLE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A blocked write is dropped when leaving RUN/STALL for FLUSH.
  assign wr_pend_nx = ((state_nx == RUN) || (state_nx == STALL)) &&
                      (reg_enh || (wr_pend && !fifo_wr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wave_l  <= '0;
      div_l   <= '0;
      blen_l  <= '0;
      presc   <= '0;
      cnt     <= '0;
      p       <= '0;
      dir_up  <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      state   <= state_nx;
      wr_pend <= wr_pend_nx;
      if (state == IDLE) begin
        if (start && !stop) begin
          wave_l <= wave_sel;
          div_l  <= div;
          blen_l <= burst_len;
          presc  <= '0;
          cnt    <= '0;
          p      <= '0;
          dir_up <= 1'b1;
        end
      end else if ((state == RUN) && !blocked) begin
        presc <= (presc == div_l) ? '0 : presc + D_ONE;
      end
      if (reg_enh) begin
        p      <= p_nx;
        dir_up <= dir_nx;
        if (blen_l != '0) cnt <= cnt + B_ONE;
      end
    end
  end

endmodule

// File: tb/tb_funct_generator_ctrl.sv
module tb_funct_generator_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [1:0]  wave_sel;
  logic [15:0] div;
  logic [15:0] burst_len;
  logic        fifo_full;
  logic [7:0]  sample_d;
  logic        reg_enh, reg_clrh, fifo_wr, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  funct_generator_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(16), .BURST_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .wave_sel(wave_sel),
    .div(div), .burst_len(burst_len), .fifo_full(fifo_full),
    .sample_d(sample_d), .reg_enh(reg_enh), .reg_clrh(reg_clrh),
    .fifo_wr(fifo_wr), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // k-th sample (0-based) of each waveform, straight from the definitions.
  function automatic int wave_model(input int w, input int k);
    int m;
    case (w)
      0: return k % 256;
      1: begin
        m = k % 510;
        return (m <= 255) ? m : 510 - m;
      end
      2: return ((k % 256) >= 128) ? 255 : 0;
      default: return 255 - (k % 256);
    endcase
  endfunction

  // One start..end transaction. bp_pct < 0 holds fifo_full for cycles 3-7;
  // stop_after > 0 raises stop on the tick after that many samples.
  task automatic run_case(input int w, input int d, input int blen,
                          input int bp_pct, input int stop_after);
    int  n_enh, n_wr, a, cyc, pending, qm, prev_sd;
    bit  stalled, full, act, tk, stop_now, exp_enh, exp_wr, exp_done, fin;
    n_enh = 0; n_wr = 0; a = 0; cyc = 0; qm = 0; prev_sd = 0;
    stalled = 0; fin = 0;

    @(posedge clk); #1;
    start = 1; stop = 0; wave_sel = 2'(w); div = 16'(d); burst_len = 16'(blen);
    fifo_full = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_enh", reg_enh, 0);

    while (!fin) begin
      cyc++;
      @(posedge clk); #1;
      start = 0;
      wave_sel = 2'($urandom); div = 16'($urandom); burst_len = 16'($urandom);
      if (bp_pct < 0) full = (cyc >= 3 && cyc < 8);
      else            full = ($urandom_range(0, 99) < bp_pct);
      pending = n_enh - n_wr;
      exp_wr  = (pending > 0) && !full;
      act     = !stalled && !((pending > 0) && full);
      if (act) a++;
      tk       = act && (a % (d + 1) == 0);
      stop_now = (stop_after > 0) && (n_enh == stop_after) && tk;
      exp_enh  = tk && !stop_now && (blen == 0 || n_enh < blen);
      exp_done = exp_wr && !stop_now && (blen > 0) && (n_wr + 1 == blen);
      fifo_full = full;
      stop      = stop_now;
      @(negedge clk);
      check("enh", reg_enh, int'(exp_enh));
      check("wr", fifo_wr, int'(exp_wr));
      check("done", done, int'(exp_done));
      check("busy", busy, 1);
      check("clrh", reg_clrh, 0);
      if (stalled) check("stall_hold", sample_d, prev_sd);
      if (exp_enh) check("sample", sample_d, wave_model(w, n_enh));
      if (exp_wr) begin
        check("fifo_data", qm, wave_model(w, n_wr));
        n_wr++;
      end
      if (reg_enh) qm = sample_d;
      if (exp_enh) n_enh++;
      stalled = stalled ? full : ((pending > 0) && full);
      prev_sd = sample_d;
      if (stop_now || exp_done) fin = 1;
      if (cyc > 4000) begin
        check("timeout", 1, 0);
        fin = 1;
      end
    end

    @(posedge clk); #1;
    stop = 0; fifo_full = 0;
    @(negedge clk);
    if (stop_after > 0) begin
      check("flush_clrh", reg_clrh, 1);
      check("flush_enh", reg_enh, 0);
      check("flush_wr", fifo_wr, 0);
      check("flush_done", done, 0);
      check("flush_busy", busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("end_busy", busy, 0);
    check("end_clrh", reg_clrh, 0);
    check("end_enh", reg_enh, 0);
    check("end_wr", fifo_wr, 0);
  endtask

  initial begin
    int blen, sa;
    rst = 0; start = 0; stop = 0; wave_sel = 0; div = 0; burst_len = 0; fifo_full = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sample", sample_d, 0);
    check("rst_wr", fifo_wr, 0);
    rst = 1;

    run_case(0, 0, 4, 0, 0);      // sawtooth burst of 4
    run_case(1, 2, 0, 0, 512);    // triangle through both turnarounds
    run_case(0, 0, 12, -1, 0);    // 5-cycle backpressure hold
    run_case(0, 4, 0, 0, 3);      // stop on a tick
    run_case(3, 0, 3, 0, 0);      // ramp-down
    run_case(2, 0, 130, 0, 0);    // square edge at sample 128

    // start with stop in IDLE is ignored
    @(posedge clk); #1; start = 1; stop = 1;
    @(negedge clk); check("ss_busy0", busy, 0);
    @(posedge clk); #1; start = 0; stop = 0;
    @(negedge clk); check("ss_busy1", busy, 0);

    // asynchronous reset mid-run, then restart from sample 0
    @(posedge clk); #1; start = 1; wave_sel = 2'b01; div = 3; burst_len = 0;
    @(posedge clk); #1; start = 0;
    repeat (9) @(posedge clk);
    #2; rst = 0; #1;
    check("arst_busy", busy, 0);
    check("arst_enh", reg_enh, 0);
    check("arst_clrh", reg_clrh, 0);
    check("arst_wr", fifo_wr, 0);
    check("arst_done", done, 0);
    check("arst_sample", sample_d, 0);
    @(negedge clk); rst = 1;
    @(negedge clk); check("arst_idle", busy, 0);
    run_case(1, 3, 0, 0, 5);

    for (int i = 0; i < 12; i++) begin
      blen = $urandom_range(1, 12);
      sa   = (blen > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, blen - 1) : 0;
      run_case($urandom_range(0, 3), $urandom_range(0, 4), blen, $urandom_range(0, 60), sa);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/funct_generator_ctrl.md
Name: funct_generator_ctrl

Overview:
- Sequencer for the function-generator datapath.
- Computes waveform samples and drives the 8-bit sample register's d, enh and clrh inputs.
- Pushes each registered sample into the downstream FIFO with a write strobe, honouring FIFO backpressure.
- Sits between the configuration/control interface and the sample-register + FIFO pair.

Parameters:
DATA_WIDTH, 8, sample width; must match the sample register and FIFO width.
DIV_WIDTH, 16, width of the sample-rate divider.
BURST_WIDTH, 16, width of the burst-length counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset (0 = reset).
start  input  1  start request; sampled only in IDLE.
stop  input  1  abort request; sampled in any non-IDLE state.
wave_sel  input  2  00 sawtooth, 01 triangle, 10 square, 11 ramp-down.
div  input  DIV_WIDTH  sample period minus 1, in clk cycles.
burst_len  input  BURST_WIDTH  number of samples to emit; 0 = continuous.
fifo_full  input  1  FIFO full flag.
sample_d  output  DATA_WIDTH  next sample, to register d.
reg_enh  output  1  register load enable.
reg_clrh  output  1  register synchronous clear.
fifo_wr  output  1  FIFO write strobe; FIFO captures register q.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse on the final burst write.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; phase, direction, prescaler, burst counter and wr_pend all cleared.
- States: IDLE, RUN, STALL, FLUSH. busy = (state != IDLE).

IDLE:
- start=1 and stop=0: latch wave_sel, div and burst_len; clear phase p, prescaler, burst count and wr_pend; direction = up; go to RUN next cycle.
- start and stop both high: stop wins; remain in IDLE.

RUN:
- Prescaler counts 0..div_latched. A tick occurs when prescaler == div_latched; prescaler then returns to 0.
- First tick falls div+1 cycles after the start cycle; ticks then repeat every div+1 cycles. div=0 gives a tick every cycle.
- On a tick, if stop=0 and the burst is not exhausted:
  - reg_enh=1 and sample_d = f(p).
  - Advance p; set wr_pend for the next cycle.
- fifo_wr = wr_pend & ~fifo_full. wr_pend clears when the write fires.

STALL:
- Entered when wr_pend=1 and fifo_full=1.
- Prescaler frozen, reg_enh=0, register q held.
- The cycle fifo_full falls: fifo_wr=1, return to RUN; prescaler resumes.
- No sample is dropped or duplicated.

Waveforms (p is DATA_WIDTH bits, wraps modulo 2^DATA_WIDTH):
- Sawtooth: sample = p.
- Ramp-down: sample = ~p.
- Square: sample = p[MSB] ? all-ones : 0. Period is 2^DATA_WIDTH samples.
- Triangle: a value v steps +1 while direction is up and -1 while down. Direction reverses after emitting all-ones or 0.
  - Sequence: 0,1,...,255,254,...,1,0,1,...
  - Period is 2*(2^DATA_WIDTH - 1) samples, with no repeated endpoints.
- The first sample after start uses p=0 (v=0).

Burst:
- burst_len=N>0: exactly N reg_enh pulses, then no further ticks.
- done=1 in the cycle of the N-th fifo_wr; the next state is IDLE. No clear is issued, so the register keeps the last sample.

Stop (RUN or STALL):
- A tick coinciding with stop is suppressed.
- A fifo_wr already enabled in the stop cycle still completes. A write blocked in STALL is discarded.
- Next cycle goes to FLUSH: reg_clrh=1 for exactly one cycle, then IDLE. done is not asserted.

Other rules:
- reg_enh and reg_clrh are never high in the same cycle.
- wave_sel, div and burst_len changes while busy are ignored.

Test Plan:
- Reset mid-RUN with wave_sel=01, div=3: drive rst=0 → all outputs 0 immediately; after release, busy=0 and the next start restarts the triangle at sample 0.
- Sawtooth, div=0, burst_len=4, fifo_full=0, start at cycle 0 → reg_enh at cycles 1-4 with sample_d 0,1,2,3; fifo_wr at cycles 2-5; done at cycle 5; busy=0 at cycle 6.
- Triangle, div=2, continuous → reg_enh every 3rd cycle; sample indices 255/256 give 255/254; index 509 gives 1, index 510 gives 0, index 511 gives 1.
- Backpressure: sawtooth, div=0, fifo_full=1 for 5 cycles while wr_pend=1 → fifo_wr=0, reg_enh=0 and sample_d/q stable for 5 cycles; the write fires the cycle full drops; the FIFO receives 0,1,2,... with no gap or duplicate.
- Stop asserted in the same cycle as a tick (div=4) → no reg_enh that cycle; any in-flight fifo_wr completes; reg_clrh=1 for one cycle next; busy=0 the cycle after; done never asserted.
- Ramp-down, div=0 → first samples 255,254,253. Square, div=0 → samples 0-127 are 0 and sample 128 is 255. start+stop together in IDLE → stays IDLE, busy=0.
